// File: rtl/router_input_arbiter.sv
// router_input_arbiter
//   Round-robin arbiter that shares the router's single byte-wide input among
//   NUM_SRC packet sources. A source keeps the grant for a whole packet
//   (header, payload, parity). The arbiter stalls while the router reports busy.
//
//   Optional build macro: DROP_BAD_ADDR_EN
//     When defined, a packet whose header addresses port 3 is drained from its
//     source and not forwarded. o_Drop pulses on the parity pop.
//     When undefined, such packets are forwarded and o_Drop is tied low.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-low reset
//   i_Req          per-source flag: a complete packet is waiting at the head of that source
//   i_Src_Data     per-source head byte (show-ahead); source k is at [k*DATA_W +: DATA_W]
//   i_Sig_Busy     router busy; no byte is accepted while it is high
//   o_Src_Pop      one-hot pop strobe to the granted source, one cycle per accepted byte
//   o_Grant        one-hot current owner; zero while idle
//   o_Valid_Packet drives the router valid-packet input
//   o_Output_Data  drives the router input data
//   o_Drop         one-cycle pulse when a packet is discarded
//
// State table
//   state   | meaning
//   IDLE    | choose the next requester round-robin; no byte moves
//   HEADER  | present the header byte; load the length counter when it is accepted
//   PAYLOAD | present payload bytes; the counter steps down once per accepted byte
//   PARITY  | present the parity byte with valid low; advance the RR pointer
//   GAP     | one dead cycle so the router returns to address decode

module router_input_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        i_Req,
    input  logic [NUM_SRC*DATA_W-1:0] i_Src_Data,
    input  logic                      i_Sig_Busy,
    output logic [NUM_SRC-1:0]        o_Src_Pop,
    output logic [NUM_SRC-1:0]        o_Grant,
    output logic                      o_Valid_Packet,
    output logic [DATA_W-1:0]         o_Output_Data,
    output logic                      o_Drop
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t             state;
    logic [IDXW-1:0]    grant_idx;
    logic [IDXW-1:0]    rr_ptr;
    logic [IDXW-1:0]    pick_idx;
    logic               pick_found;
    logic [5:0]         len_cnt;
    logic               xfer;
    logic               accept;
    logic               draining;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_SRC-1:0] grant_onehot;

    // Search starts at the RR pointer and wraps, so the most recently served
    // source is visited last.
    always_comb begin
        int              k;
        logic [IDXW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        k          = 0;
        cand       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            k    = (int'(rr_ptr) + i) % NUM_SRC;
            cand = k[IDXW-1:0];
            if (!pick_found && i_Req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign sel_data     = i_Src_Data[grant_idx*DATA_W +: DATA_W];
    assign grant_onehot = NUM_SRC'(1) << grant_idx;
    assign xfer         = (state == HEADER) || (state == PAYLOAD) || (state == PARITY);

`ifdef DROP_BAD_ADDR_EN
    logic drain_q;
    logic drain_hdr;

    // While a packet is drained it is popped every cycle, whatever busy says.
    // The router never sees it.
    assign drain_hdr = (state == HEADER) && (sel_data[1:0] == 2'b11);
    assign draining  = drain_hdr || (drain_q && ((state == PAYLOAD) || (state == PARITY)));
    assign o_Drop    = draining && (state == PARITY);
`else
    assign draining  = 1'b0;
    assign o_Drop    = 1'b0;
`endif

    assign accept         = xfer && (!i_Sig_Busy || draining);
    assign o_Src_Pop      = accept ? grant_onehot : '0;
    assign o_Grant        = xfer ? grant_onehot : '0;
    assign o_Valid_Packet = ((state == HEADER) || (state == PAYLOAD)) && !draining;
    assign o_Output_Data  = (xfer && !draining) ? sel_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            len_cnt   <= '0;
`ifdef DROP_BAD_ADDR_EN
            drain_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && !i_Sig_Busy) begin
                        grant_idx <= pick_idx;
                        state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        len_cnt <= sel_data[7:2];
`ifdef DROP_BAD_ADDR_EN
                        drain_q <= drain_hdr;
`endif
                        state   <= (sel_data[7:2] != 6'd0) ? PAYLOAD : PARITY;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        len_cnt <= len_cnt - 6'd1;
                        if (len_cnt == 6'd1) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (accept) begin
                        rr_ptr <= (grant_idx == IDXW'(NUM_SRC - 1)) ? '0 : grant_idx + IDXW'(1);
                        state  <= GAP;
                    end
                end
                GAP: begin
`ifdef DROP_BAD_ADDR_EN
                    drain_q <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_arbiter.sv
// tb_router_input_arbiter
//   Self-checking bench for router_input_arbiter. Each source is modelled as a
//   byte queue. Every loaded packet pushes its expected bytes into a scoreboard,
//   in service order. Each observed pop is compared with the front of the scoreboard.

module tb_router_input_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC-1:0]        i_Req;
    logic [NUM_SRC*DATA_W-1:0] i_Src_Data;
    logic                      i_Sig_Busy;
    logic [NUM_SRC-1:0]        o_Src_Pop;
    logic [NUM_SRC-1:0]        o_Grant;
    logic                      o_Valid_Packet;
    logic [DATA_W-1:0]         o_Output_Data;
    logic                      o_Drop;

    router_input_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_Req          (i_Req),
        .i_Src_Data     (i_Src_Data),
        .i_Sig_Busy     (i_Sig_Busy),
        .o_Src_Pop      (o_Src_Pop),
        .o_Grant        (o_Grant),
        .o_Valid_Packet (o_Valid_Packet),
        .o_Output_Data  (o_Output_Data),
        .o_Drop         (o_Drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       valid;
        logic       drop;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] src_q[NUM_SRC][$];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [NUM_SRC-1:0] s_pop;
    logic [NUM_SRC-1:0] s_grant;
    logic               s_valid;
    logic               s_drop;
    logic [7:0]         s_data;

    function automatic logic [NUM_SRC-1:0] oh(int s);
        return NUM_SRC'(1) << s;
    endfunction

    task automatic drive_src();
        for (int k = 0; k < NUM_SRC; k++) begin
            i_Req[k] = (src_q[k].size() > 0);
            i_Src_Data[k*DATA_W +: DATA_W] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
        end
    endtask

    // Loads one complete packet into a source and queues its expected bytes.
    // A dropped packet shows data 0 and valid 0 on every byte, with drop set on the parity byte.
    task automatic load_packet(int src, logic [7:0] hdr, logic [7:0] base, bit drop);
        exp_t       e;
        logic [7:0] par;
        logic [7:0] b;
        int         len;
        len = int'(hdr[7:2]);
        par = hdr;
        src_q[src].push_back(hdr);
        e.src = src; e.data = drop ? 8'h00 : hdr; e.valid = !drop; e.drop = 1'b0;
        sb.push_back(e);
        for (int i = 0; i < len; i++) begin
            b   = base + 8'(i);
            par = par ^ b;
            src_q[src].push_back(b);
            e.src = src; e.data = drop ? 8'h00 : b; e.valid = !drop; e.drop = 1'b0;
            sb.push_back(e);
        end
        src_q[src].push_back(par);
        e.src = src; e.data = drop ? 8'h00 : par; e.valid = 1'b0; e.drop = drop;
        sb.push_back(e);
        drive_src();
    endtask

    // One clock: sample at the falling edge, then apply the pops just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_pop   = o_Src_Pop;
        s_grant = o_Grant;
        s_valid = o_Valid_Packet;
        s_drop  = o_Drop;
        s_data  = o_Output_Data;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_SRC; k++)
            if (s_pop[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        drive_src();
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        i_Sig_Busy = 1'b0;
        drive_src();
        tick();
        n_checks++; if (s_grant !== '0) begin n_fail++; $display("FAIL reset_grant got=%b want=0", s_grant); end
        n_checks++; if (s_pop !== '0)   begin n_fail++; $display("FAIL reset_pop got=%b want=0", s_pop); end
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", s_valid); end
        n_checks++; if (s_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h want=00", s_data); end
        n_checks++; if (s_drop !== 1'b0)  begin n_fail++; $display("FAIL reset_drop got=%b want=0", s_drop); end
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   idle_run = 0;
        bit   seen = 0;
        int   n = 0;
        load_packet(0, 8'h04, 8'h10, 0);
        load_packet(1, 8'h09, 8'h20, 0);
        load_packet(2, 8'h0E, 8'h30, 0);
        load_packet(3, 8'h10, 8'h40, 0);
        load_packet(0, 8'h05, 8'h50, 0);
        while (sb.size() > 0 && n < 400) begin
            tick(); n++;
            if (s_grant == '0) begin
                idle_run++;
                n_checks++;
                if (s_pop !== '0 || s_valid !== 1'b0 || s_data !== 8'h00) begin
                    n_fail++; $display("FAIL rr_idle_outputs got pop=%b valid=%b data=%h want all 0", s_pop, s_valid, s_data);
                end
            end else begin
                if (seen && idle_run != 0) begin
                    n_checks++;
                    if (idle_run != 2) begin n_fail++; $display("FAIL rr_gap got=%0d idle cycles want=2", idle_run); end
                end
                idle_run = 0;
                seen     = 1;
            end
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL rr_byte got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL rr_timeout got=%0d left want=0", sb.size()); sb.delete(); end
        tick(); tick();
    endtask

    task automatic test_single_src1();
        exp_t e;
        int   pops = 0;
        load_packet(1, 8'h0D, 8'hA1, 0);
        tick();
        n_checks++;
        if (s_grant !== '0 || s_pop !== '0) begin n_fail++; $display("FAIL single_decide got grant=%b pop=%b want 0 0", s_grant, s_pop); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (s_grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant got=%b want=0010", s_grant); end
            if (s_pop != '0) begin
                pops++;
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL single_byte got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        n_checks++; if (pops != 5) begin n_fail++; $display("FAIL single_pops got=%0d want=5", pops); end
        tick();
        n_checks++;
        if (s_grant !== '0 || s_valid !== 1'b0 || s_data !== 8'h00) begin
            n_fail++; $display("FAIL single_gap got grant=%b valid=%b data=%h want 0 0 00", s_grant, s_valid, s_data);
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL single_left got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_busy_stall();
        exp_t e;
        load_packet(2, 8'h0E, 8'hB1, 0);
        for (int c = 0; c < 10; c++) begin
            i_Sig_Busy = (c >= 3 && c <= 5);
            tick();
            if (i_Sig_Busy) begin
                n_checks++;
                if (s_pop !== '0 || s_data !== 8'hB2 || s_grant !== 4'b0100 || s_valid !== 1'b1) begin
                    n_fail++; $display("FAIL busy_hold got pop=%b data=%h grant=%b valid=%b want 0000 b2 0100 1",
                                       s_pop, s_data, s_grant, s_valid);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (s_grant !== '0) begin n_fail++; $display("FAIL busy_gap got grant=%b want=0", s_grant); end
            end
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL busy_byte got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        i_Sig_Busy = 1'b0;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL busy_left got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_zero_len();
        exp_t e;
        int   pops = 0;
        load_packet(1, 8'h02, 8'h00, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (s_pop != '0) begin
                pops++;
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL zlen_byte got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        n_checks++; if (pops != 2) begin n_fail++; $display("FAIL zlen_pops got=%0d want=2", pops); end
        if (sb.size() != 0) begin sb.delete(); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n = 0;
        load_packet(2, 8'h12, 8'hC1, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid) begin
                    n_fail++; $display("FAIL rmid_byte got pop=%b data=%h valid=%b want pop=%b data=%h valid=%b",
                                       s_pop, s_data, s_valid, oh(e.src), e.data, e.valid);
                end
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (o_Grant !== '0 || o_Src_Pop !== '0 || o_Valid_Packet !== 1'b0 || o_Output_Data !== 8'h00) begin
            n_fail++; $display("FAIL rmid_async got grant=%b pop=%b valid=%b data=%h want all 0",
                               o_Grant, o_Src_Pop, o_Valid_Packet, o_Output_Data);
        end
        src_q[2].delete();
        sb.delete();
        drive_src();
        tick();
        reset = 1'b1;
        load_packet(0, 8'h08, 8'hD1, 0);
        load_packet(3, 8'h05, 8'hE1, 0);
        while (sb.size() > 0 && n < 100) begin
            tick(); n++;
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL rmid_order got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL rmid_timeout got=%0d left want=0", sb.size()); sb.delete(); end
        tick(); tick();
    endtask

`ifdef DROP_BAD_ADDR_EN
    task automatic test_drop();
        exp_t e;
        int   pops = 0;
        int   n = 0;
        load_packet(1, 8'h05, 8'h91, 0);
        while (sb.size() > 0 && n < 50) begin
            tick(); n++;
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid) begin
                    n_fail++; $display("FAIL drop_pre got pop=%b data=%h valid=%b want pop=%b data=%h valid=%b",
                                       s_pop, s_data, s_valid, oh(e.src), e.data, e.valid);
                end
            end
        end
        sb.delete();
        tick(); tick();
        load_packet(3, 8'h0B, 8'hF1, 1);
        tick();
        i_Sig_Busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (s_pop != '0) begin
                pops++;
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL drop_byte got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        n_checks++; if (pops != 4) begin n_fail++; $display("FAIL drop_pops got=%0d want=4", pops); end
        sb.delete();
        tick();
        load_packet(0, 8'h04, 8'h61, 0);
        load_packet(3, 8'h04, 8'h71, 0);
        i_Sig_Busy = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick(); n++;
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL drop_next got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL drop_timeout got=%0d left want=0", sb.size()); sb.delete(); end
        tick(); tick();
    endtask
`else
    task automatic test_bad_addr_forward();
        exp_t e;
        int   n = 0;
        load_packet(3, 8'h07, 8'h81, 0);
        while (sb.size() > 0 && n < 50) begin
            tick(); n++;
            if (s_pop != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (s_pop !== oh(e.src) || s_data !== e.data || s_valid !== e.valid || s_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL fwd_byte got pop=%b data=%h valid=%b drop=%b want pop=%b data=%h valid=%b drop=%b",
                             s_pop, s_data, s_valid, s_drop, oh(e.src), e.data, e.valid, e.drop);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL fwd_timeout got=%0d left want=0", sb.size()); sb.delete(); end
        tick(); tick();
    endtask
`endif

    initial begin
        i_Req      = '0;
        i_Src_Data = '0;
        i_Sig_Busy = 1'b0;
        reset      = 1'b0;
        test_reset();
        test_round_robin();
        test_single_src1();
        test_busy_stall();
        test_zero_len();
        test_reset_mid();
`ifdef DROP_BAD_ADDR_EN
        test_drop();
`else
        test_bad_addr_forward();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/router_input_arbiter.md
Name: router_input_arbiter

Overview:
Round-robin arbiter that shares the router's single byte-wide input between NUM_SRC packet sources. It grants one source for a whole packet: header, payload, then parity. It drives the router's valid-packet and data inputs, and honours router busy by stalling. It sits directly upstream of the router top level.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_W, 8, byte width; header layout fixed as [7:2] payload length, [1:0] destination

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
i_Req  input  NUM_SRC  per-source: complete packet waiting at head of source buffer
i_Src_Data  input  NUM_SRC*DATA_W  per-source head byte, show-ahead; source k at bits [k*8+7:k*8]
i_Sig_Busy  input  1  router busy; no byte accepted while high
o_Src_Pop  output  NUM_SRC  one-hot pop strobe to granted source, one cycle per accepted byte
o_Grant  output  NUM_SRC  one-hot current owner, zero when idle
o_Valid_Packet  output  1  to router valid-packet input
o_Output_Data  output  DATA_W  to router input data
o_Drop  output  1  one-cycle pulse when a packet is discarded (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state IDLE; o_Grant=0; o_Src_Pop=0; o_Valid_Packet=0; o_Output_Data=0; RR pointer=0; length counter=0.
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - If any i_Req and i_Sig_Busy=0, grant the first requester searching from the RR pointer upward, with wrap.
  - Register the grant and go to HEADER next cycle.
  - Decision takes 1 cycle; no byte moves in IDLE.
- Transfer rule: in HEADER, PAYLOAD or PARITY, a byte is accepted in a cycle where i_Sig_Busy=0.
  - o_Src_Pop[grant] is high that cycle.
  - o_Output_Data = granted i_Src_Data (combinational mux of the registered grant).
- HEADER:
  - o_Valid_Packet=1.
  - On accept: load the 6-bit counter with header[7:2].
  - Next state is PAYLOAD if length ≠ 0, else PARITY.
- PAYLOAD:
  - o_Valid_Packet=1.
  - On accept: decrement the counter; at counter=1, go to PARITY.
- PARITY:
  - o_Valid_Packet=0 while the parity byte is presented (router low-packet-valid convention).
  - On accept: go to GAP.
  - Advance the RR pointer to (granted index + 1) mod NUM_SRC.
- GAP:
  - One mandatory idle cycle: o_Grant cleared, o_Valid_Packet=0, o_Output_Data=0.
  - Then go to IDLE. This guarantees the router FSM returns to address decode.
- Busy stall: when i_Sig_Busy=1, state, counter and grant are held, no pop occurs, and the same byte stays on o_Output_Data.
- Grant is sticky for the whole packet. Deassertion of i_Req[grant] mid-packet is ignored; sources must hold a complete packet before raising i_Req.
- Requests arriving mid-packet wait; no preemption.
- Maximum packet length is 63 payload bytes; the counter never wraps.
- Outside transfer states, o_Src_Pop=0 and o_Output_Data=0.
- Reset asserted mid-packet: immediate return to reset values. The partially sent packet is abandoned; the router recovers via its own reset.

Optional Feature:
Macro DROP_BAD_ADDR_EN.
- Defined: a header with [1:0]=2'b11 (no such output port) is drained, not forwarded.
  - Every byte of the packet is popped on consecutive cycles, ignoring i_Sig_Busy.
  - o_Valid_Packet=0 and o_Output_Data=0 throughout.
  - o_Drop pulses in the PARITY pop cycle.
  - The RR pointer advances as for a normal packet.
- Undefined: such packets are forwarded unchanged, and o_Drop is tied 0.

Test Plan:
- Src1 only, header 0x0D (len 3, port 1), payload A1 A2 A3, parity P, busy=0 -> grant 4'b0010 after 1 cycle; 5 consecutive pops; valid=1 for 4 bytes, 0 on P; then GAP cycle.
- All 4 sources request continuously, pointer=0 -> packets served in order 0,1,2,3,0; each packet separated by a GAP plus an IDLE cycle.
- Busy asserted 3 cycles during payload byte 2 -> byte 2 held on o_Output_Data for 3 cycles; no pops; counter unchanged; completes after busy drops.
- Header 0x02 (len 0, port 2) -> HEADER then directly PARITY; exactly 2 pops.
- Reset pulled low mid-payload of src2 -> all outputs 0 same cycle; after release, src0 request is granted first (pointer=0).
- DROP_BAD_ADDR_EN defined, header 0x0B (len 2, port 3) on src3 -> 4 pops with valid=0 even while busy=1; o_Drop pulse on the 4th pop; the next grant goes to src0.
